// File: rtl/io_resp_pkg.sv
// io_resp_pkg: shared constants and types for the IO responder.
//   IO_REGION / STATUS_OFF : region tag and status register offset
//   ST_*                   : status word bit positions
//   io_wentry_t            : posted-write FIFO entry {slot, offset, data}
//   status_word()          : packs the status register read value
package io_resp_pkg;

  localparam logic [7:0]  IO_REGION  = 8'hC0;
  localparam logic [23:0] STATUS_OFF = 24'hFF_FFFC;

  localparam int unsigned ST_OVF_BIT  = 0;
  localparam int unsigned ST_LVL_LSB  = 8;
  localparam int unsigned ST_LVL_W    = 8;
  localparam int unsigned ST_DROP_LSB = 16;
  localparam int unsigned ST_DROP_W   = 16;

  // Entry fields sized for the widest legal configuration; the top
  // zero-extends its slot/offset into them.
  localparam int unsigned SLOT_FW = 8;
  localparam int unsigned OFF_FW  = 22;

  typedef struct packed {
    logic [SLOT_FW-1:0] slot;
    logic [OFF_FW-1:0]  offset;
    logic [31:0]        data;
  } io_wentry_t;

  function automatic logic [31:0] status_word(
    input logic                 ovf,
    input logic [ST_LVL_W-1:0]  level,
    input logic [ST_DROP_W-1:0] drops
  );
    logic [31:0] w;
    w = '0;
    w[ST_OVF_BIT]                  = ovf;
    w[ST_LVL_LSB  +: ST_LVL_W]     = level;
    w[ST_DROP_LSB +: ST_DROP_W]    = drops;
    return w;
  endfunction

endpackage

// File: rtl/io_wfifo.sv
// io_wfifo: circular buffer for posted IO writes.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_push, i_din  : enqueue request and entry (caller guarantees room)
//   i_pop          : dequeue request (caller guarantees non-empty)
//   o_head         : oldest entry
//   o_full/o_empty : occupancy flags
//   o_level        : number of stored entries
//   o_by_age       : entries ordered oldest (index 0) to youngest; only
//                    the first o_level are meaningful
module io_wfifo
  import io_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  io_wentry_t               i_din,
  input  logic                     i_pop,
  output io_wentry_t               o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output io_wentry_t               o_by_age [DEPTH]
);

  localparam int unsigned PW = $clog2(DEPTH);

  io_wentry_t    r_mem [DEPTH];
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [PW:0]   r_level;

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      o_by_age[k] = r_mem[r_rptr + PW'(k)];
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_level = r_level;
  assign o_full  = (r_level == (PW+1)'(DEPTH));
  assign o_empty = (r_level == '0);

endmodule

// File: rtl/io_responder.sv
// io_responder: target endpoint of the CPU memory-mapped IO port for
// region 0xC000_0000-0xC0FF_FFFF.
//   CLK, RESET            : clock, synchronous active-high reset
//   IO_A, IOReadS,
//   IOWriteS, IO_write    : CPU single-cycle strobes, address, write data
//   IO_dout               : registered read data (valid the cycle after)
//   p_we/p_wsel/p_waddr/
//   p_wdata, p_wready     : posted-write FIFO head towards peripherals
//   p_re/p_rsel/p_raddr,
//   p_rdata               : combinational read channel to peripherals
// Build option: define IO_RD_FWD_EN to forward posted write data to
// reads of the same slot/offset (youngest entry wins).
module io_responder
  import io_resp_pkg::*;
#(
  parameter int unsigned NUM_SLOTS   = 4,
  parameter int unsigned SLOT_LSB    = 11,
  parameter int unsigned WFIFO_DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [31:0]            IO_A,
  input  logic [1:0]             IOReadS,
  input  logic                   IOWriteS,
  input  logic [31:0]            IO_write,
  output logic [31:0]            IO_dout,
  output logic [NUM_SLOTS-1:0]   p_wsel,
  output logic [SLOT_LSB-3:0]    p_waddr,
  output logic [31:0]            p_wdata,
  output logic                   p_we,
  input  logic [NUM_SLOTS-1:0]   p_wready,
  output logic [NUM_SLOTS-1:0]   p_rsel,
  output logic [SLOT_LSB-3:0]    p_raddr,
  output logic                   p_re,
  input  logic [NUM_SLOTS*32-1:0] p_rdata
);

  localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned OW = SLOT_LSB - 2;
  localparam int unsigned LW = $clog2(WFIFO_DEPTH) + 1;

`ifdef IO_RD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic          w_in_region;
  logic          w_is_status;
  logic [SW-1:0] w_slot;
  logic [OW-1:0] w_off;
  logic          w_rd;
  logic          w_wr_data;
  logic          w_wr_status;

  io_wentry_t    w_new;
  io_wentry_t    w_head;
  io_wentry_t    w_by_age [WFIFO_DEPTH];
  logic          w_full;
  logic          w_empty;
  logic [LW-1:0] w_level;
  logic [SW-1:0] w_head_slot;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;

  logic          w_fwd_hit;
  logic [31:0]   w_fwd_data;
  logic [31:0]   w_slot_rdata;

  logic          r_ovf;
  logic [15:0]   r_drops;

  logic          w_unused;

  // Address decode; byte lane bits are ignored everywhere, including the
  // status register match.
  assign w_in_region = (IO_A[31:24] == IO_REGION);
  assign w_is_status = (IO_A[23:2] == STATUS_OFF[23:2]);
  assign w_slot      = IO_A[SLOT_LSB +: SW];
  assign w_off       = IO_A[SLOT_LSB-1:2];
  assign w_rd        = (|IOReadS) && w_in_region;
  assign w_wr_data   = IOWriteS && w_in_region && !w_is_status;
  assign w_wr_status = IOWriteS && w_in_region && w_is_status;

  assign p_re    = w_rd;
  assign p_rsel  = NUM_SLOTS'(1) << w_slot;
  assign p_raddr = w_off;

  always_comb begin
    w_new        = '0;
    w_new.slot   = SLOT_FW'(w_slot);
    w_new.offset = OFF_FW'(w_off);
    w_new.data   = IO_write;
  end

  io_wfifo #(
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .i_clk    (CLK),
    .i_rst    (RESET),
    .i_push   (w_push),
    .i_din    (w_new),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_level  (w_level),
    .o_by_age (w_by_age)
  );

  assign w_head_slot = w_head.slot[SW-1:0];
  assign p_we        = !w_empty;
  assign p_wsel      = p_we ? (NUM_SLOTS'(1) << w_head_slot) : '0;
  assign p_waddr     = w_head.offset[OW-1:0];
  assign p_wdata     = w_head.data;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_pop  = p_we && p_wready[w_head_slot];
  assign w_push = w_wr_data && (!w_full || w_pop);
  assign w_drop = w_wr_data && w_full && !w_pop;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ovf   <= 1'b0;
      r_drops <= '0;
    end else if (w_wr_status) begin
      r_ovf   <= 1'b0;
      r_drops <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drops != '1) r_drops <= r_drops + 1'b1;
    end
  end

  // Scan oldest to youngest so the last hit is the youngest entry; a write
  // pushed this cycle shares IO_A with the read, so it always matches and
  // is younger than everything stored.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int unsigned k = 0; k < WFIFO_DEPTH; k++) begin
      if ((LW'(k) < w_level) &&
          (w_by_age[k].slot == SLOT_FW'(w_slot)) &&
          (w_by_age[k].offset == OFF_FW'(w_off))) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_by_age[k].data;
      end
    end
    if (w_push) begin
      w_fwd_hit  = 1'b1;
      w_fwd_data = IO_write;
    end
  end

  assign w_slot_rdata = p_rdata[{w_slot, 5'b0} +: 32];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      IO_dout <= '0;
    end else if (w_rd) begin
      if (w_is_status) begin
        IO_dout <= status_word(r_ovf, ST_LVL_W'(w_level), r_drops);
      end else if (FWD_EN && w_fwd_hit) begin
        IO_dout <= w_fwd_data;
      end else begin
        IO_dout <= w_slot_rdata;
      end
    end
  end

  assign w_unused = ^{IO_A[1:0], w_head.slot[SLOT_FW-1:SW], w_head.offset[OFF_FW-1:OW]};

endmodule

// File: tb/tb_io_responder.sv
module tb_io_responder;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  IO_A;
  logic [1:0]   IOReadS;
  logic         IOWriteS;
  logic [31:0]  IO_write;
  logic [31:0]  IO_dout;
  logic [3:0]   p_wsel;
  logic [8:0]   p_waddr;
  logic [31:0]  p_wdata;
  logic         p_we;
  logic [3:0]   p_wready;
  logic [3:0]   p_rsel;
  logic [8:0]   p_raddr;
  logic         p_re;
  logic [127:0] p_rdata;

  io_responder #(
    .NUM_SLOTS   (4),
    .SLOT_LSB    (11),
    .WFIFO_DEPTH (4)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .IO_A     (IO_A),
    .IOReadS  (IOReadS),
    .IOWriteS (IOWriteS),
    .IO_write (IO_write),
    .IO_dout  (IO_dout),
    .p_wsel   (p_wsel),
    .p_waddr  (p_waddr),
    .p_wdata  (p_wdata),
    .p_we     (p_we),
    .p_wready (p_wready),
    .p_rsel   (p_rsel),
    .p_raddr  (p_raddr),
    .p_re     (p_re),
    .p_rdata  (p_rdata)
  );

  always #5 CLK = ~CLK;

  // Reference model: the FIFO is a plain queue of posted writes.
  typedef struct {
    int unsigned slot;
    int unsigned off;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_dout;
  logic        m_ovf;
  int unsigned m_drops;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {m_drops[15:0], 8'(q.size()), 7'b0, m_ovf};
  endfunction

  // Applies one clock edge to the model using the inputs present at the edge.
  task automatic model_step();
    bit          in_reg, is_stat, rd, wr, pop, pushed, hit;
    int unsigned slot, off;
    logic [31:0] fdata;
    if (RESET) begin
      q.delete();
      m_dout  = '0;
      m_ovf   = 1'b0;
      m_drops = 0;
      return;
    end
    in_reg  = (IO_A[31:24] == 8'hC0);
    is_stat = (IO_A[23:2] == 22'h3FFFFF);
    rd      = (IOReadS != 2'b00) && in_reg;
    wr      = IOWriteS && in_reg;
    slot    = IO_A[12:11];
    off     = IO_A[10:2];
    pop     = (q.size() > 0) && p_wready[q[0].slot];
    pushed  = wr && !is_stat && (q.size() < 4 || pop);
    if (rd) begin
      if (is_stat) begin
        m_dout = m_status();
      end else begin
        hit   = 1'b0;
        fdata = '0;
`ifdef IO_RD_FWD_EN
        foreach (q[i]) begin
          if (q[i].slot == slot && q[i].off == off) begin
            hit   = 1'b1;
            fdata = q[i].data;
          end
        end
        if (pushed) begin
          hit   = 1'b1;
          fdata = IO_write;
        end
`endif
        m_dout = hit ? fdata : p_rdata[slot*32 +: 32];
      end
    end
    if (wr && is_stat) begin
      m_ovf   = 1'b0;
      m_drops = 0;
    end else if (wr && !pushed) begin
      m_ovf = 1'b1;
      if (m_drops < 16'hFFFF) m_drops++;
    end
    if (pop) void'(q.pop_front());
    if (pushed) q.push_back('{slot: slot, off: off, data: IO_write});
  endtask

  // Registered outputs against the model, once per cycle.
  always @(negedge CLK) begin
    if (run_cmp) begin
      chk("IO_dout", IO_dout, m_dout);
      chk("p_we", 32'(p_we), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("p_wsel", 32'(p_wsel), 32'(4'b0001 << q[0].slot));
        chk("p_waddr", 32'(p_waddr), q[0].off);
        chk("p_wdata", p_wdata, q[0].data);
      end
    end
  end

  // One clock: drive at negedge+1, check combinational read-side outputs,
  // step the model at the edge, return 1 time unit after the edge.
  task automatic cyc(input logic rst, input logic [1:0] rs, input logic ws,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] wrdy, input logic [127:0] rdat);
    @(negedge CLK);
    #1;
    RESET    = rst;
    IOReadS  = rs;
    IOWriteS = ws;
    IO_A     = a;
    IO_write = d;
    p_wready = wrdy;
    p_rdata  = rdat;
    #1;
    if (run_cmp) begin
      chk("p_re", 32'(p_re), 32'((rs != 2'b00) && (a[31:24] == 8'hC0)));
      chk("p_rsel", 32'(p_rsel), 32'(4'b0001 << a[12:11]));
      chk("p_raddr", 32'(p_raddr), 32'(a[10:2]));
    end
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk({name, "_model"}, m_dout, exp);
    chk(name, act, exp);
  endtask

  logic [127:0] rd99;
  logic [31:0]  fwd_exp;
  logic [31:0]  drain_exp [3];
  logic [31:0]  a_r;
  logic [1:0]   rs_r;

  initial begin
    RESET = 1'b1; IOReadS = '0; IOWriteS = 1'b0; IO_A = '0; IO_write = '0;
    p_wready = '0; p_rdata = '0;
    m_dout = '0; m_ovf = 1'b0; m_drops = 0;

    cyc(1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 4'h0, '0);
    cyc(1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 4'h0, '0);
    run_cmp = 1'b1;
    lit("reset_dout", IO_dout, 32'h0);
    chk("reset_we", 32'(p_we), 32'h0);

    // status read straight after reset
    cyc(1'b0, 2'b01, 1'b0, 32'hC0FF_FFFC, 32'h0, 4'h0, {4{32'h5555_AAAA}});
    lit("status_after_reset", IO_dout, 32'h0000_0000);

    // single write to slot 1, offset 1, drained immediately
    cyc(1'b0, 2'b00, 1'b1, 32'hC000_0804, 32'hDEAD_BEEF, 4'hF, '0);
    chk("first_we", 32'(p_we), 32'h1);
    chk("first_wsel", 32'(p_wsel), 32'h2);
    chk("first_waddr", 32'(p_waddr), 32'h1);
    chk("first_wdata", p_wdata, 32'hDEAD_BEEF);
    cyc(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 4'hF, '0);
    chk("first_popped", 32'(p_we), 32'h0);

    // six writes into a stalled FIFO: four kept, two dropped
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 2'b00, 1'b1, 32'hC000_0000 + 32'(4 * i), 32'(i + 1), 4'h0, '0);
    cyc(1'b0, 2'b10, 1'b0, 32'hC0FF_FFFC, 32'h0, 4'h0, '0);
    lit("status_overflow", IO_dout, 32'h0002_0401);
    cyc(1'b0, 2'b00, 1'b1, 32'hC0FF_FFFC, 32'h0, 4'h0, '0);
    cyc(1'b0, 2'b11, 1'b0, 32'hC0FF_FFFC, 32'h0, 4'h0, '0);
    lit("status_cleared", IO_dout, 32'h0000_0400);

    // full FIFO: push and pop in the same cycle
    cyc(1'b0, 2'b00, 1'b1, 32'hC000_0018, 32'h77, 4'hF, '0);
    cyc(1'b0, 2'b01, 1'b0, 32'hC0FF_FFFC, 32'h0, 4'h0, '0);
    lit("status_full_pushpop", IO_dout, 32'h0000_0400);
    chk("head_after_pushpop", p_wdata, 32'h2);
    drain_exp[0] = 32'h3; drain_exp[1] = 32'h4; drain_exp[2] = 32'h77;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 4'hF, '0);
      chk("drain_order", p_wdata, drain_exp[i]);
    end
    cyc(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 4'hF, '0);
    chk("drained_empty", 32'(p_we), 32'h0);

    // read-after-write to the same register while writes are stalled
    rd99 = '0;
    rd99[64 +: 32] = 32'h99;
    cyc(1'b0, 2'b00, 1'b1, 32'hC000_1008, 32'h11, 4'h0, rd99);
    cyc(1'b0, 2'b00, 1'b1, 32'hC000_1008, 32'h22, 4'h0, rd99);
    cyc(1'b0, 2'b01, 1'b0, 32'hC000_1008, 32'h0, 4'h0, rd99);
`ifdef IO_RD_FWD_EN
    fwd_exp = 32'h22;
`else
    fwd_exp = 32'h99;
`endif
    lit("raw_read", IO_dout, fwd_exp);

    // out-of-region read leaves IO_dout alone
    cyc(1'b0, 2'b01, 1'b0, 32'h8000_0000, 32'h0, 4'h0, {4{32'hCAFE_F00D}});
    chk("oor_p_re", 32'(p_re), 32'h0);
    lit("oor_dout_held", IO_dout, fwd_exp);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 4'hF, '0);

    // randomized traffic; few slots/offsets so forwarding hits often
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 6)       a_r = 32'hC0FF_FFFC | 32'($urandom_range(0, 3));
      else if (r < 14) a_r = $urandom;
      else             a_r = {8'hC0, 11'h0, 2'($urandom_range(0, 3)), 7'h0,
                              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      rs_r = ($urandom_range(0, 9) < 4) ? 2'($urandom_range(1, 3)) : 2'b00;
      cyc(($urandom_range(0, 299) == 0), rs_r, ($urandom_range(0, 9) < 5),
          a_r, $urandom, 4'($urandom & $urandom),
          {$urandom, $urandom, $urandom, $urandom});
    end

    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_responder.md
# io_responder

Target-side endpoint of the CPU's memory-mapped IO port. Accepts the CPU's single-cycle IO read/write strobes for region `0xC000_0000`–`0xC0FF_FFFF` and decodes them to per-slot peripheral channels. Writes are posted through a small FIFO so that slow peripherals never stall the core. Reads return registered data with fixed one-cycle latency.

## Interface
Parameters:
- `NUM_SLOTS`, 4: number of peripheral slots; must be a power of 2.
- `SLOT_LSB`, 11: address bit where the slot index starts, giving 2 KB per slot.
- `WFIFO_DEPTH`, 4: depth of the posted-write FIFO; must be a power of 2, at least 2.

Ports:
- `CLK` in 1: the single clock.
- `RESET` in 1: synchronous, active-high.
- `IO_A` in 32: byte address from the CPU.
- `IOReadS` in 2: read strobe; any nonzero value means a read.
- `IOWriteS` in 1: write strobe.
- `IO_write` in 32: write data.
- `IO_dout` out 32: registered read data to the CPU.
- `p_wsel` out NUM_SLOTS: one-hot slot select for the FIFO head.
- `p_waddr` out SLOT_LSB-2: word offset of the head entry.
- `p_wdata` out 32: data of the head entry.
- `p_we` out 1: head entry valid.
- `p_wready` in NUM_SLOTS: per-slot write accept.
- `p_rsel` out NUM_SLOTS: one-hot read slot, combinational from `IO_A`.
- `p_raddr` out SLOT_LSB-2: read word offset, combinational.
- `p_re` out 1: read pulse, equal to read strobe AND the address is in the IO region.
- `p_rdata` in NUM_SLOTS×32: per-slot combinational read data.

## Operation
- **Region decode:** an access is in the IO region when `IO_A[31:24]==8'hC0`. Strobes outside the region are ignored (no push, `IO_dout` unchanged).
- **Field decode:**
  - slot = `IO_A[SLOT_LSB +: log2(NUM_SLOTS)]`.
  - offset = `IO_A[SLOT_LSB-1:2]`.
  - `IO_A[1:0]` is ignored.
- **Status register:** located at `IO_A[23:0]==24'hFF_FFFC`.
  - Read layout: `[0]` sticky overflow, `[7:1]` zero, `[15:8]` FIFO level, `[31:16]` drop count.
  - A write to this address clears the overflow flag and the drop count, and is not pushed into the FIFO.
- **Write push:** an in-region, non-status write pushes {slot, offset, data}.
  - If the FIFO is full and no pop happens in the same cycle, the write is dropped, overflow is set, and the drop count increments, saturating at `16'hFFFF`.
- **Drain:** the head entry drives `p_we`, `p_wsel`, `p_waddr` and `p_wdata`. The entry pops in any cycle where `p_we && p_wready[head slot]`. Drain is in order and the head is never skipped.
- **Push and pop together:** both occur in the same cycle and the level is unchanged. This is legal when the FIFO is full.
- **Read path:**
  - `IO_dout` is loaded with the status word, or with `p_rdata[slot]`, or with the forwarded value (see Configuration).
  - `IO_dout` holds its value until the next in-region read.
- **Read and write together:** when the read and write strobes are asserted in the same cycle, both are processed. The read sees the pre-write peripheral state unless forwarding is enabled.
- **Status read timing:** the level reported is the value before any same-cycle push or pop.

## Timing
- Reset values: `IO_dout`=0, FIFO empty, `p_we`=0, overflow=0, drop count=0.
- Read latency: `IO_dout` is valid on the cycle after the strobe cycle, matching the CPU's sampling.
- Write latency: a pushed entry appears on `p_we` no earlier than one cycle after the strobe, because there is no bypass around the FIFO.
- Pop: with `p_wready` held high, one entry pops per cycle.
- The level counter is `log2(WFIFO_DEPTH)+1` bits wide. Read and write pointers wrap modulo `WFIFO_DEPTH`.
- `RESET` asserted mid-drain discards all entries in the next cycle. Peripherals must tolerate `p_we` falling without an accept.

## Configuration
- `IO_RD_FWD_EN` defined:
  - A read whose slot and offset match a FIFO entry returns the data of the youngest matching entry.
  - A write pushed in the same cycle counts as younger than all entries.
  - Status reads are never forwarded.
- `IO_RD_FWD_EN` undefined:
  - Reads always return `p_rdata[slot]`.
  - Software must poll for status level == 0 before doing a read-after-write to the same register.

## Structure
- Package `io_resp_pkg` holds:
  - `IO_REGION` = `8'hC0`.
  - `STATUS_OFF` = `24'hFF_FFFC`.
  - typedef `io_wentry_t` = {slot, offset, data}.
  - The status bit-position constants.
- Sub-module `io_wfifo`: a parameterised circular buffer providing push/pop, full/empty and level. It exposes its entries for the forwarding compare.
- Top-level `io_responder` contains the decode, the status register, the read mux and the forwarding logic.

## Test plan
- Reset, then read `0xC0FF_FFFC` → `IO_dout`=`32'h0000_0000` one cycle later.
- Write `0xDEADBEEF` to `0xC000_0804` with `p_wready`=all 1 → next cycle `p_we`=1, `p_wsel`=`4'b0010`, `p_waddr`=1, `p_wdata`=`0xDEADBEEF`. The pop happens in that cycle and the FIFO is then empty.
- `p_wready`=0, then issue 6 writes to slot 0 → level 4, then read status → `0x0002_0401`. Write the status register, then read it → `0x0000_0400`.
- FIFO full while a push and a pop land in the same cycle → no drop and level stays 4. Drain order matches push order.
- `IO_RD_FWD_EN` set, `p_wready`=0: write `0x11` then `0x22` to `0xC000_1008`, then read it → `IO_dout`=`0x22` while `p_rdata[2]`=`0x99`. With the macro unset, the same sequence returns `0x99`.
- Read of `0x8000_0000` with `p_re` low → `IO_dout` unchanged.
